// File: rtl/perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : perf_pkg
//  Purpose  : Shared types and helpers for the performance counter bank:
//             FSM state encoding, read-selector width helper and the
//             selector value that addresses the cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
package perf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } perf_state_e;

   // Selector 0 always addresses the free-running cycle counter.
   localparam int CYCLE_SEL = 0;

   // Bits needed to address the cycle counter plus every event counter.
   function automatic int sel_w(input int num_events);
      return $clog2(num_events + 1);
   endfunction

endpackage : perf_pkg
`default_nettype wire

// File: rtl/perf_counter_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank_if
//  Purpose  : Read port of the performance counter bank.
//  Ports    : rd_en/rd_sel   request (master -> slave)
//             rd_data        registered counter value (slave -> master)
//             rd_valid       rd_data valid this cycle
//             rd_err         selector out of range
//  Revision : 1.0  initial release
// ============================================================================
interface perf_counter_bank_if #(
   parameter int NUM_EVENTS = 6,
   parameter int CNT_W      = 32
);
   localparam int SEL_W = perf_pkg::sel_w(NUM_EVENTS);

   logic             rd_en;
   logic [SEL_W-1:0] rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic             rd_valid;
   logic             rd_err;

   modport master (output rd_en, output rd_sel,
                   input  rd_data, input rd_valid, input rd_err);
   modport slave  (input  rd_en, input rd_sel,
                   output rd_data, output rd_valid, output rd_err);
endinterface : perf_counter_bank_if
`default_nettype wire

// File: rtl/perf_counter.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter
//  Purpose  : One CNT_W-bit event counter with synchronous clear, optional
//             saturation and a sticky overflow flag.
//  Ports    : clk, rst_n     clock, async active-low reset
//             inc            count this cycle
//             clr            zero count and overflow flag (wins over inc)
//             cnt            current count
//             ovf            sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter #(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b1
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              inc,
   input  wire              clr,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc) begin
         if (&cnt_q) begin
            // Increment at all-ones: flag it, then stick or wrap.
            ovf_d = 1'b1;
            cnt_d = SATURATE ? cnt_q : '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule : perf_counter
`default_nettype wire

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : perf_counter_bank
//  Purpose  : Cycle counter plus NUM_EVENTS event counters gated by an
//             IDLE/RUN/HALTED state machine, with a registered read port.
//  Ports    : clk, rst_n     clock, async active-low reset
//             start/clear/halt  control strobes (clear has priority)
//             event_i        per-cycle event strobes (bit k -> counter k+1)
//             rd_if          read port (slave side)
//             ovf            sticky overflow flags, bit 0 = cycle counter
//             running/halted state indications, done = entry into HALTED
//  Revision : 1.0  initial release
// ============================================================================
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int NUM_EVENTS = 6,
   parameter int CNT_W      = 32,
   parameter bit SATURATE   = 1'b1
) (
   input  wire                   clk,
   input  wire                   rst_n,
   input  wire                   start,
   input  wire                   clear,
   input  wire                   halt,
   input  wire  [NUM_EVENTS-1:0] event_i,
   perf_counter_bank_if.slave    rd_if,
   output logic [NUM_EVENTS:0]   ovf,
   output logic                  running,
   output logic                  halted,
   output logic                  done
);

   localparam int SEL_W = sel_w(NUM_EVENTS);

   perf_state_e      state_q, state_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_err_q, rd_err_d;

   logic             count_en;
   logic [NUM_EVENTS:0] inc_vec;
   logic [CNT_W-1:0] cnt_arr [NUM_EVENTS+1];

   // ---------------- state machine ----------------
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (clear) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (halt) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                     end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
         endcase
      end
   end

   // The halt cycle is still counted; clear overrides counting.
   assign count_en = (state_q == RUN) && !clear;

   always_comb begin
      inc_vec            = '0;
      inc_vec[CYCLE_SEL] = count_en;
      for (int k = 1; k <= NUM_EVENTS; k++) begin
         inc_vec[k] = count_en & event_i[k-1];
      end
   end

   // ---------------- counters ----------------
   for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
      perf_counter #(
         .CNT_W    (CNT_W),
         .SATURATE (SATURATE)
      ) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .inc   (inc_vec[g]),
         .clr   (clear),
         .cnt   (cnt_arr[g]),
         .ovf   (ovf[g])
      );
   end

   // ---------------- read port ----------------
   // Reads return the pre-edge counter value; rd_data holds when idle.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      rd_err_d   = 1'b0;
      if (rd_if.rd_en) begin
         rd_valid_d = 1'b1;
         rd_data_d  = '0;
         if (rd_if.rd_sel > SEL_W'(NUM_EVENTS)) begin
            rd_err_d = 1'b1;
         end else begin
            for (int k = 0; k <= NUM_EVENTS; k++) begin
               if (rd_if.rd_sel == SEL_W'(k)) rd_data_d = cnt_arr[k];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign rd_if.rd_data  = rd_data_q;
   assign rd_if.rd_valid = rd_valid_q;
   assign rd_if.rd_err   = rd_err_q;
   assign running        = (state_q == RUN);
   assign halted         = (state_q == HALTED);
   assign done           = done_q;

endmodule : perf_counter_bank
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_perf_counter_bank
//  Purpose  : Directed self-checking bench. One 32-bit saturating bank plus
//             two 8-bit banks (saturating and wrapping) share the controls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_perf_counter_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       clear = 1'b0;
   logic       halt  = 1'b0;
   logic [5:0] event_i = '0;

   logic [6:0] ovf_m, ovf_s, ovf_w;
   logic       run_m, run_s, run_w;
   logic       hlt_m, hlt_s, hlt_w;
   logic       done_m, done_s, done_w;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   perf_counter_bank_if #(.NUM_EVENTS(6), .CNT_W(32)) bus_m ();
   perf_counter_bank_if #(.NUM_EVENTS(6), .CNT_W(8))  bus_s ();
   perf_counter_bank_if #(.NUM_EVENTS(6), .CNT_W(8))  bus_w ();

   perf_counter_bank #(.NUM_EVENTS(6), .CNT_W(32), .SATURATE(1'b1)) u_dut_m (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt(halt),
      .event_i(event_i), .rd_if(bus_m), .ovf(ovf_m),
      .running(run_m), .halted(hlt_m), .done(done_m));

   perf_counter_bank #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt(halt),
      .event_i(event_i), .rd_if(bus_s), .ovf(ovf_s),
      .running(run_s), .halted(hlt_s), .done(done_s));

   perf_counter_bank #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b0)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .halt(halt),
      .event_i(event_i), .rd_if(bus_w), .ovf(ovf_w),
      .running(run_w), .halted(hlt_w), .done(done_w));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock edge, then settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic en, input logic [2:0] sel);
      bus_m.rd_en = en; bus_m.rd_sel = sel;
      bus_s.rd_en = en; bus_s.rd_sel = sel;
      bus_w.rd_en = en; bus_w.rd_sel = sel;
   endtask

   // Single read on the 32-bit bank, in a state where counts are static.
   task automatic rd_m(input string tag, input logic [2:0] sel, input logic [63:0] exp);
      set_rd(1'b1, sel);
      step();
      chk({tag, "_valid"}, 64'(bus_m.rd_valid), 64'd1);
      chk(tag, 64'(bus_m.rd_data), exp);
      set_rd(1'b0, 3'd0);
   endtask

   logic [31:0] exp_b2b [8];
   int done_cnt;

   initial begin
      exp_b2b = '{32'd0, 32'd1, 32'd0, 32'd3, 32'd4, 32'd0, 32'd6, 32'd0};
      set_rd(1'b0, 3'd0);

      // ---- reset state ----
      #12;
      chk("rst_running", 64'(run_m), 64'd0);
      chk("rst_halted",  64'(hlt_m), 64'd0);
      chk("rst_done",    64'(done_m), 64'd0);
      chk("rst_ovf",     64'(ovf_m), 64'd0);
      chk("rst_rd_valid", 64'(bus_m.rd_valid), 64'd0);
      chk("rst_rd_data", 64'(bus_m.rd_data), 64'd0);
      rst_n = 1'b1;
      step();

      // ---- start, 10 event cycles, halt (halt cycle counted) ----
      start = 1'b1;
      step();
      chk("start_running", 64'(run_m), 64'd1);
      start = 1'b0;
      event_i = 6'b000001;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (done_m) done_cnt++;
      end
      halt = 1'b1;
      step();
      chk("halt_done", 64'(done_m), 64'd1);
      chk("halt_halted", 64'(hlt_m), 64'd1);
      chk("halt_running", 64'(run_m), 64'd0);
      halt = 1'b0;
      event_i = '0;
      step();
      chk("done_pulse_end", 64'(done_m), 64'd0);
      chk("done_early", 64'(done_cnt), 64'd0);
      rd_m("h_cyc", 3'd0, 64'd11);
      rd_m("h_ev1", 3'd1, 64'd11);
      for (int s = 2; s <= 6; s++) rd_m("h_evx", 3'(s), 64'd0);

      // ---- HALTED: events and start ignored ----
      for (int i = 0; i < 20; i++) begin
         event_i = 6'(i * 13 + 5);
         start   = i[0];
         step();
         if (run_m !== 1'b0) chk("halted_run", 64'(run_m), 64'd0);
      end
      start = 1'b0;
      event_i = '0;
      chk("halted_stay", 64'(hlt_m), 64'd1);
      rd_m("hh_cyc", 3'd0, 64'd11);
      rd_m("hh_ev1", 3'd1, 64'd11);
      rd_m("hh_ev2", 3'd2, 64'd0);

      // ---- clear, then back-to-back reads during RUN ----
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_halted", 64'(hlt_m), 64'd0);
      rd_m("clr_cyc", 3'd0, 64'd0);
      event_i = 6'b101101;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 8; s++) begin
         set_rd(1'b1, 3'(s));
         step();
         chk("b2b_valid", 64'(bus_m.rd_valid), 64'd1);
         chk("b2b_data",  64'(bus_m.rd_data), 64'(exp_b2b[s]));
         chk("b2b_err",   64'(bus_m.rd_err), (s == 7) ? 64'd1 : 64'd0);
      end
      set_rd(1'b0, 3'd0);
      step();
      chk("idle_valid", 64'(bus_m.rd_valid), 64'd0);
      chk("idle_err",   64'(bus_m.rd_err), 64'd0);

      // ---- clear + halt same cycle in RUN ----
      clear = 1'b1;
      halt  = 1'b1;
      step();
      clear = 1'b0;
      halt  = 1'b0;
      event_i = '0;
      chk("ch_done",    64'(done_m), 64'd0);
      chk("ch_halted",  64'(hlt_m), 64'd0);
      chk("ch_running", 64'(run_m), 64'd0);
      chk("ch_ovf",     64'(ovf_m), 64'd0);
      rd_m("ch_cyc", 3'd0, 64'd0);
      rd_m("ch_ev4", 3'd4, 64'd0);

      // ---- overflow: event 2 for 300 counted cycles ----
      event_i = 6'b000010;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 299; i++) step();
      halt = 1'b1;
      step();
      halt = 1'b0;
      event_i = '0;
      set_rd(1'b1, 3'd2);
      step();
      set_rd(1'b0, 3'd0);
      chk("ovf_m_cnt2", 64'(bus_m.rd_data), 64'd300);
      chk("ovf_s_cnt2", 64'(bus_s.rd_data), 64'd255);
      chk("ovf_w_cnt2", 64'(bus_w.rd_data), 64'd44);
      chk("ovf_m_flags", 64'(ovf_m), 64'd0);
      chk("ovf_s_flags", 64'(ovf_s), 64'b0000101);
      chk("ovf_w_flags", 64'(ovf_w), 64'b0000101);
      set_rd(1'b1, 3'd0);
      step();
      set_rd(1'b0, 3'd0);
      chk("ovf_s_cyc", 64'(bus_s.rd_data), 64'd255);
      chk("ovf_w_cyc", 64'(bus_w.rd_data), 64'd44);
      step();
      chk("ovf_sticky", 64'(ovf_w), 64'b0000101);

      // ---- asynchronous reset mid-RUN ----
      clear = 1'b1;
      step();
      clear = 1'b0;
      event_i = 6'b000001;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      set_rd(1'b1, 3'd0);
      step();
      set_rd(1'b0, 3'd0);
      chk("pre_rst_data", 64'(bus_m.rd_data), 64'd4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_running", 64'(run_m), 64'd0);
      chk("arst_valid",   64'(bus_m.rd_valid), 64'd0);
      chk("arst_data",    64'(bus_m.rd_data), 64'd0);
      chk("arst_ovf",     64'(ovf_s), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      set_rd(1'b1, 3'd1);
      step();
      set_rd(1'b0, 3'd0);
      chk("recount_ev1", 64'(bus_m.rd_data), 64'd3);
      chk("recount_run", 64'(run_m), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_perf_counter_bank
`default_nettype wire
